ddr_burst_seq: RTL and testbench
================================

# ddr_burst_seq

Controller-side data-path sequencer that drives the DDR PHY data port and receives its capture data. For each accepted burst command it waits the write or read latency and drives `tx_dat_o`, `dq_en` and `dqm_en` from the TX FIFO, or forwards `rx_dat_i` to the RX FIFO. It sits between the command FSM/FIFOs and the PHY data path, and owns all data-phase timing.

## Interface
Parameters:
- `WL`, 3: write latency, cycles from command accept to preamble cycle (1..15).
- `RL`, 5: read latency, cycles from command accept to first capture edge (1..15).
- `TURN`, 2: idle gap after every burst before the next accept (0..15).

Ports:
- `sdram_clk_0`  in  1  sole clock.
- `wb_rst_n`  in  1  async active-low reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  ready to accept a command; high only in IDLE.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_bl`  in  1  0 = BL4 (2 words), 1 = BL8 (4 words).
- `fifo_dat_i`  in  36  TX FIFO head, show-ahead:
  - [35:20] first beat, [19:4] second beat.
  - [3:0] byte enables, 1 = byte written.
- `fifo_empty`  in  1  TX FIFO empty.
- `fifo_rd`  out  1  pop TX FIFO.
- `tx_dat_o`  out  36  word to PHY, same format as `fifo_dat_i`.
- `dq_en`  out  1  PHY output enable for DQ/DQS/DM.
- `dqm_en`  out  1  force all bytes masked.
- `rx_dat_i`  in  36  PHY capture word.
- `rx_dat_o`  out  36  word to RX FIFO.
- `rx_valid`  out  1  `rx_dat_o` valid (push RX FIFO).
- `busy`  out  1  state != IDLE.
- `err_underrun`  out  1  sticky: TX FIFO was empty during a write word.
- `err_clr`  in  1  clears `err_underrun`.

## Operation
- States: IDLE, WLAT, WPRE, WBURST, RLAT, RBURST, TURN.
- IDLE: `cmd_ready` = 1. On `cmd_valid & cmd_ready`:
  - latch `cmd_we` and word count N (2 or 4);
  - load the latency counter;
  - go to WLAT or RLAT.
- WLAT: count down. Enter WPRE so that `dq_en` = 1 and `dqm_en` = 1 are visible from edge T+WL, where T is the accept edge. `tx_dat_o` = 0 in the preamble.
- WPRE/WBURST (write data):
  - Each cycle whose ending edge loads a data word asserts `fifo_rd` iff `!fifo_empty`, and loads `tx_dat_o` <= `fifo_dat_i` with `dqm_en` <= 0.
  - If `fifo_empty`: no pop, `tx_dat_o` <= 0, `dqm_en` <= 1, set `err_underrun`.
  - The burst never stalls; exactly N words issue.
- After the last write word: `dq_en` <= 0, `dqm_en` <= 0, go to TURN.
- RLAT: count down. `rx_dat_o` <= `rx_dat_i` at edges T+RL .. T+RL+N-1, with `rx_valid` = 1 for those N cycles. Then go to TURN.
- TURN: hold TURN cycles (TURN = 0 skips the state), then go to IDLE.
- `err_clr` and a new underrun in the same cycle: set wins.
- Word counter is 2 bits; latency counter is 4 bits, with no wrap beyond loaded values.

## Timing
- Reset (async assert, sync-safe deassert) drives these outputs to 0: `cmd_ready`, `fifo_rd`, `tx_dat_o`, `dq_en`, `dqm_en`, `rx_dat_o`, `rx_valid`, `busy`, `err_underrun`.
- `cmd_ready` = 1 from the first edge after reset release.
- Reset mid-burst: outputs go to 0 immediately, state goes to IDLE, the burst is abandoned, and no further pops occur.
- All outputs are registered except `cmd_ready` and `fifo_rd`, which decode the current state and inputs combinationally.
- Write: `dq_en` is high for N+1 cycles (preamble plus N words). Data words appear at edges T+WL+1 .. T+WL+N.
- Read: first `rx_valid` at edge T+RL.
- Command-to-command: the next accept is no earlier than burst end + TURN + 1 cycle.

## Structure
- Shared package/header `ddr_seq_defs` holds:
  - state encodings;
  - word-count constants for BL4 = 2 and BL8 = 4;
  - field positions: beat0 [35:20], beat1 [19:4], BE [3:0].
- One natural sub-module: `ddr_seq_cnt`, a 4-bit loadable down-counter with zero flag, used for the latency and TURN counts.
- The FSM and data registers stay in the top.

## Test plan
- Reset release, then a BL4 write with WL = 3 and FIFO holding 0xAAAA_5555_F and 0x1234_5678_3 -> `dq_en` high at T+3..T+5; `tx_dat_o` = the two words at T+4 and T+5; `dqm_en` = 1 only at T+3; 2 pops.
- BL8 read with RL = 5 and `rx_dat_i` = 0x1..0x4 at edges T+5..T+8 -> `rx_valid` 4 cycles, `rx_dat_o` = 0x1..0x4 in order, `dq_en` stays 0.
- BL4 write with FIFO empty on the second word -> second word has `tx_dat_o` = 0 and `dqm_en` = 1; 1 pop; `err_underrun` = 1 until `err_clr`.
- Back-to-back write then read with TURN = 2 and `cmd_valid` held -> read accepted exactly 3 cycles after the write burst ends; `cmd_ready` = 0 throughout.
- `wb_rst_n` low during the third word of a BL8 write -> `dq_en`, `fifo_rd`, `busy` = 0 immediately; after release `cmd_ready` = 1 and the next command behaves normally.
- `err_clr` coincident with a new underrun -> `err_underrun` stays 1.

Source files
------------

// File: rtl/ddr_burst_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ddr_seq_defs : state encodings, burst word counts and word field positions
// Rev 1.0
//------------------------------------------------------------------------------
package ddr_seq_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLAT   = 3'd1,
        ST_WPRE   = 3'd2,
        ST_WBURST = 3'd3,
        ST_RLAT   = 3'd4,
        ST_RBURST = 3'd5,
        ST_TURN   = 3'd6
    } state_t;

    localparam int c_DAT_W     = 36;
    localparam int c_WORDS_BL4 = 2;
    localparam int c_WORDS_BL8 = 4;

    localparam int c_BEAT0_MSB = 35;
    localparam int c_BEAT0_LSB = 20;
    localparam int c_BEAT1_MSB = 19;
    localparam int c_BEAT1_LSB = 4;
    localparam int c_BE_MSB    = 3;
    localparam int c_BE_LSB    = 0;

    // Words still to move after the first one of a burst
    function automatic logic [1:0] words_after_first(input logic i_bl);
        return i_bl ? 2'(c_WORDS_BL8 - 1) : 2'(c_WORDS_BL4 - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_burst_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// ddr_burst_seq_if : command, TX/RX FIFO, PHY data and status signals
// Rev 1.0
//------------------------------------------------------------------------------
interface ddr_burst_seq_if;
    import ddr_seq_defs::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_we;
    logic               cmd_bl;
    logic [c_DAT_W-1:0] fifo_dat_i;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [c_DAT_W-1:0] tx_dat_o;
    logic               dq_en;
    logic               dqm_en;
    logic [c_DAT_W-1:0] rx_dat_i;
    logic [c_DAT_W-1:0] rx_dat_o;
    logic               rx_valid;
    logic               busy;
    logic               err_underrun;
    logic               err_clr;

    modport slave (
        input  cmd_valid, cmd_we, cmd_bl, fifo_dat_i, fifo_empty, rx_dat_i, err_clr,
        output cmd_ready, fifo_rd, tx_dat_o, dq_en, dqm_en, rx_dat_o, rx_valid,
               busy, err_underrun
    );

    modport master (
        output cmd_valid, cmd_we, cmd_bl, fifo_dat_i, fifo_empty, rx_dat_i, err_clr,
        input  cmd_ready, fifo_rd, tx_dat_o, dq_en, dqm_en, rx_dat_o, rx_valid,
               busy, err_underrun
    );

endinterface
`default_nettype wire

// File: rtl/ddr_burst_seq_cnt.sv
`default_nettype none
//------------------------------------------------------------------------------
// ddr_seq_cnt : 4-bit loadable down-counter, saturating at zero, with zero flag
// Rev 1.0
//------------------------------------------------------------------------------
module ddr_seq_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ddr_burst_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// ddr_burst_seq : data-phase sequencer between command FSM/FIFOs and DDR PHY
// Rev 1.0
//------------------------------------------------------------------------------
module ddr_burst_seq
    import ddr_seq_defs::*;
#(
    parameter int WL   = 3,
    parameter int RL   = 5,
    parameter int TURN = 2
) (
    input  logic            sdram_clk_0,
    input  logic            wb_rst_n,
    ddr_burst_seq_if.slave  bus
);

    localparam logic [3:0] c_WL_LD     = 4'(WL - 1);
    localparam logic [3:0] c_RL_LD     = 4'(RL - 1);
    localparam logic [3:0] c_TURN_LD   = (TURN > 0) ? 4'(TURN - 1) : 4'd0;
    localparam state_t     c_AFTER_BST = (TURN > 0) ? ST_TURN : ST_IDLE;

    state_t             r_state, w_state_nxt;
    logic               r_alive;
    logic [1:0]         r_last, w_last_nxt;
    logic [1:0]         r_wrem, w_wrem_nxt;
    logic [c_DAT_W-1:0] r_tx, w_tx_nxt;
    logic               r_dq_en, w_dq_en_nxt;
    logic               r_dqm, w_dqm_nxt;
    logic [c_DAT_W-1:0] r_rx, w_rx_nxt;
    logic               r_rx_valid, w_rx_valid_nxt;
    logic               r_busy;
    logic               r_err, w_err_nxt;
    logic               w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [3:0]         w_cnt_val;
    logic               w_ready, w_wr_word;
    logic [c_DAT_W-1:0] w_tx_word;

    ddr_seq_cnt u_cnt (
        .clk    (sdram_clk_0),
        .rst_n  (wb_rst_n),
        .i_load (w_cnt_load),
        .i_val  (w_cnt_val),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    // r_alive keeps cmd_ready low until the first edge after reset release
    assign w_ready   = r_alive && (r_state == ST_IDLE);
    assign w_wr_word = (r_state == ST_WPRE) || ((r_state == ST_WBURST) && (r_wrem != 2'd0));
    assign w_tx_word = bus.fifo_empty ? '0 :
                       {bus.fifo_dat_i[c_BEAT0_MSB:c_BEAT0_LSB],
                        bus.fifo_dat_i[c_BEAT1_MSB:c_BEAT1_LSB],
                        bus.fifo_dat_i[c_BE_MSB:c_BE_LSB]};

    always_ff @(posedge sdram_clk_0 or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_wrem_nxt     = r_wrem;
        w_tx_nxt       = r_tx;
        w_dq_en_nxt    = r_dq_en;
        w_dqm_nxt      = r_dqm;
        w_rx_nxt       = r_rx;
        w_rx_valid_nxt = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_val      = 4'd0;
        w_cnt_dec      = 1'b0;
        w_err_nxt      = (r_err && !bus.err_clr) || (w_wr_word && bus.fifo_empty);

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && w_ready) begin
                    w_last_nxt  = words_after_first(bus.cmd_bl);
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = bus.cmd_we ? c_WL_LD : c_RL_LD;
                    w_state_nxt = bus.cmd_we ? ST_WLAT : ST_RLAT;
                end
            end
            ST_WLAT: begin
                if (w_cnt_zero) begin
                    w_dq_en_nxt = 1'b1;
                    w_dqm_nxt   = 1'b1;
                    w_tx_nxt    = '0;
                    w_state_nxt = ST_WPRE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_WPRE: begin
                w_tx_nxt    = w_tx_word;
                w_dqm_nxt   = bus.fifo_empty;
                w_wrem_nxt  = r_last;
                w_state_nxt = ST_WBURST;
            end
            ST_WBURST: begin
                if (r_wrem != 2'd0) begin
                    w_tx_nxt   = w_tx_word;
                    w_dqm_nxt  = bus.fifo_empty;
                    w_wrem_nxt = r_wrem - 2'd1;
                end else begin
                    w_tx_nxt    = '0;
                    w_dq_en_nxt = 1'b0;
                    w_dqm_nxt   = 1'b0;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_TURN_LD;
                    w_state_nxt = c_AFTER_BST;
                end
            end
            ST_RLAT: begin
                if (w_cnt_zero) begin
                    w_rx_nxt       = bus.rx_dat_i;
                    w_rx_valid_nxt = 1'b1;
                    w_wrem_nxt     = r_last;
                    w_state_nxt    = ST_RBURST;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_RBURST: begin
                if (r_wrem != 2'd0) begin
                    w_rx_nxt       = bus.rx_dat_i;
                    w_rx_valid_nxt = 1'b1;
                    w_wrem_nxt     = r_wrem - 2'd1;
                end else begin
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_TURN_LD;
                    w_state_nxt = c_AFTER_BST;
                end
            end
            ST_TURN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sdram_clk_0 or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_alive    <= 1'b0;
            r_last     <= 2'd0;
            r_wrem     <= 2'd0;
            r_tx       <= '0;
            r_dq_en    <= 1'b0;
            r_dqm      <= 1'b0;
            r_rx       <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_alive    <= 1'b1;
            r_last     <= w_last_nxt;
            r_wrem     <= w_wrem_nxt;
            r_tx       <= w_tx_nxt;
            r_dq_en    <= w_dq_en_nxt;
            r_dqm      <= w_dqm_nxt;
            r_rx       <= w_rx_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_err      <= w_err_nxt;
        end
    end

    assign bus.cmd_ready    = w_ready;
    assign bus.fifo_rd      = w_wr_word && !bus.fifo_empty;
    assign bus.tx_dat_o     = r_tx;
    assign bus.dq_en        = r_dq_en;
    assign bus.dqm_en       = r_dqm;
    assign bus.rx_dat_o     = r_rx;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.busy         = r_busy;
    assign bus.err_underrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ddr_burst_seq : directed checks of write/read timing, underrun, turnaround
// Rev 1.0
//------------------------------------------------------------------------------
module tb_ddr_burst_seq;

    localparam int WL_T   = 3;
    localparam int RL_T   = 5;
    localparam int TURN_T = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   pops;

    logic [35:0] q[$];
    logic [35:0] e_tx [4];
    bit          e_msk[4];

    ddr_burst_seq_if bus ();

    ddr_burst_seq #(.WL(WL_T), .RL(RL_T), .TURN(TURN_T)) dut (
        .sdram_clk_0 (clk),
        .wb_rst_n    (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fifo_head();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_dat_i = (q.size() == 0) ? 36'hEEEE_EEEE_E : q[0];
    endtask

    // Samples fifo_rd before the edge, then models the show-ahead pop
    task automatic tick();
        bit p;
        #1;
        p = bus.fifo_rd;
        @(posedge clk);
        @(negedge clk);
        if (p && (q.size() > 0)) begin
            void'(q.pop_front());
            pops++;
        end
        fifo_head();
    endtask

    task automatic cmd(input logic we, input logic bl);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_bl    = bl;
        #1;
        check("cmd_ready_before_accept", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && (n < 50)) begin
            tick();
            n++;
        end
        check(tag, bus.busy, 1'b0);
    endtask

    task automatic wr_burst(input int n, input logic bl, input int exp_pops, input string tag);
        int p0;
        int idx;
        logic e_dq, e_dqm;
        logic [35:0] e_d;
        p0 = pops;
        cmd(1'b1, bl);
        for (int k = 0; k <= WL_T + n + 1; k++) begin
            if (k > 0) tick();
            idx   = k - WL_T - 1;
            e_dq  = (k >= WL_T) && (k <= WL_T + n);
            e_dqm = (k == WL_T);
            e_d   = '0;
            if ((idx >= 0) && (idx < n)) begin
                e_dqm = e_msk[idx];
                e_d   = e_tx[idx];
            end
            check($sformatf("%s_dq_k%0d", tag, k), bus.dq_en, e_dq);
            check($sformatf("%s_dqm_k%0d", tag, k), bus.dqm_en, e_dqm);
            check($sformatf("%s_tx_k%0d", tag, k), bus.tx_dat_o, e_d);
        end
        check({tag, "_pops"}, 36'(pops - p0), 36'(exp_pops));
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pops  = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_bl    = 1'b0;
        bus.rx_dat_i  = '0;
        bus.err_clr   = 1'b0;
        fifo_head();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dq_en", bus.dq_en, 1'b0);
        check("rst_tx", bus.tx_dat_o, 36'h0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_err", bus.err_underrun, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready_pre_edge", bus.cmd_ready, 1'b0);
        tick();
        check("rel_cmd_ready", bus.cmd_ready, 1'b1);

        // BL4 write
        q.push_back(36'hAAAA_5555_F);
        q.push_back(36'h1234_5678_3);
        fifo_head();
        e_tx[0] = 36'hAAAA_5555_F; e_msk[0] = 1'b0;
        e_tx[1] = 36'h1234_5678_3; e_msk[1] = 1'b0;
        wr_burst(2, 1'b0, 2, "wr4");
        check("wr4_err", bus.err_underrun, 1'b0);

        // BL8 read
        cmd(1'b0, 1'b1);
        for (int k = 1; k <= RL_T + 4; k++) begin
            bus.rx_dat_i = ((k >= RL_T) && (k <= RL_T + 3)) ? 36'(k - RL_T + 1) : 36'hF0F0_F0F0_F;
            tick();
            check($sformatf("rd8_valid_k%0d", k), bus.rx_valid, (k >= RL_T) && (k <= RL_T + 3));
            if ((k >= RL_T) && (k <= RL_T + 3))
                check($sformatf("rd8_dat_k%0d", k), bus.rx_dat_o, 36'(k - RL_T + 1));
            check($sformatf("rd8_dq_k%0d", k), bus.dq_en, 1'b0);
        end
        wait_idle("rd8_idle");

        // BL4 write, FIFO runs dry on the second word
        q.push_back(36'hC0FF_EE12_5);
        fifo_head();
        e_tx[0] = 36'hC0FF_EE12_5; e_msk[0] = 1'b0;
        e_tx[1] = 36'h0;           e_msk[1] = 1'b1;
        wr_burst(2, 1'b0, 1, "urun");
        tick();
        check("urun_err_sticky", bus.err_underrun, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("urun_err_cleared", bus.err_underrun, 1'b0);

        // Write then read back to back with cmd_valid held
        q.push_back(36'h0102_0304_F);
        q.push_back(36'h0506_0708_F);
        fifo_head();
        bus.rx_dat_i = 36'h5A5A_5A5A_5;
        cmd(1'b1, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        #1;
        check("b2b_ready_k0", bus.cmd_ready, 1'b0);
        for (int k = 1; k <= WL_T + 5; k++) begin
            tick();
            check($sformatf("b2b_ready_k%0d", k), bus.cmd_ready, k == WL_T + 5);
        end
        tick();
        bus.cmd_valid = 1'b0;
        check("b2b_rd_busy", bus.busy, 1'b1);
        check("b2b_rd_dq", bus.dq_en, 1'b0);
        for (int k = WL_T + 7; k <= WL_T + 13; k++) begin
            tick();
            check($sformatf("b2b_rxv_k%0d", k), bus.rx_valid,
                  (k == WL_T + 6 + RL_T) || (k == WL_T + 7 + RL_T));
        end
        check("b2b_rx_dat", bus.rx_dat_o, 36'h5A5A_5A5A_5);
        wait_idle("b2b_idle");

        // Reset asserted while the third word of a BL8 write is on the bus
        q.delete();
        q.push_back(36'h1111_1111_1);
        q.push_back(36'h2222_2222_2);
        q.push_back(36'h3333_3333_3);
        q.push_back(36'h4444_4444_4);
        fifo_head();
        pops = 0;
        cmd(1'b1, 1'b1);
        for (int k = 1; k <= WL_T + 3; k++) tick();
        check("mrst_word3", bus.tx_dat_o, 36'h3333_3333_3);
        rst_n = 1'b0;
        #1;
        check("mrst_dq_en", bus.dq_en, 1'b0);
        check("mrst_fifo_rd", bus.fifo_rd, 1'b0);
        check("mrst_busy", bus.busy, 1'b0);
        check("mrst_tx", bus.tx_dat_o, 36'h0);
        tick();
        tick();
        check("mrst_pops", 36'(pops), 36'd3);
        rst_n = 1'b1;
        tick();
        check("mrst_cmd_ready", bus.cmd_ready, 1'b1);
        q.delete();
        q.push_back(36'h9876_5432_1);
        q.push_back(36'hFEDC_BA98_7);
        fifo_head();
        e_tx[0] = 36'h9876_5432_1; e_msk[0] = 1'b0;
        e_tx[1] = 36'hFEDC_BA98_7; e_msk[1] = 1'b0;
        wr_burst(2, 1'b0, 2, "post_rst");

        // err_clr in the same cycle as a fresh underrun
        q.delete();
        fifo_head();
        cmd(1'b1, 1'b0);
        for (int k = 1; k <= WL_T; k++) tick();
        check("clr_set_before", bus.err_underrun, 1'b0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_set_wins", bus.err_underrun, 1'b1);
        check("clr_set_dqm", bus.dqm_en, 1'b1);
        wait_idle("clr_set_idle");
        check("clr_set_hold", bus.err_underrun, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
